// File: rtl/simon_pkg.sv
// Shared types, constants and helpers for the Simon128/256 engine.
package simon_pkg;

    localparam int WORD_WIDTH     = 64;
    localparam int ROUNDS_128_256 = 72;

    localparam logic [WORD_WIDTH-1:0] C = 64'hFFFF_FFFF_FFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [61:0] rev62(input logic [61:0] v);
        logic [61:0] r;
        for (int i = 0; i < 62; i++) begin
            r[i] = v[61-i];
        end
        return r;
    endfunction

    // The literal is written in sequence order; reversing it puts sequence position i at bit i.
    localparam logic [61:0] Z4 =
        rev62(62'b11010001111001101011011000100000010111000011001010010011101111);

    function automatic logic [WORD_WIDTH-1:0] rotl(input logic [WORD_WIDTH-1:0] v, input int n);
        return (v << n) | (v >> (WORD_WIDTH - n));
    endfunction

    function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] v, input int n);
        return (v >> n) | (v << (WORD_WIDTH - n));
    endfunction

    // Round indices never exceed 72, so a single conditional subtract gives idx mod 62.
    function automatic logic z4_at(input logic [6:0] idx);
        logic [5:0] m;
        m = (idx >= 7'd62) ? 6'(idx - 7'd62) : idx[5:0];
        return Z4[m];
    endfunction

endpackage

// File: rtl/simon_round.sv
// One Simon128/256 round plus one on-the-fly key-schedule step; purely combinational.
module simon_round
    import simon_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] x_i,
    input  logic [WORD_WIDTH-1:0] y_i,
    input  logic [WORD_WIDTH-1:0] k0_i,
    input  logic [WORD_WIDTH-1:0] k1_i,
    input  logic [WORD_WIDTH-1:0] k2_i,
    input  logic [WORD_WIDTH-1:0] k3_i,
    input  logic                  z_i,
    output logic [WORD_WIDTH-1:0] x_o,
    output logic [WORD_WIDTH-1:0] y_o,
    output logic [WORD_WIDTH-1:0] k0_o,
    output logic [WORD_WIDTH-1:0] k1_o,
    output logic [WORD_WIDTH-1:0] k2_o,
    output logic [WORD_WIDTH-1:0] k3_o
);

    logic [WORD_WIDTH-1:0] f;
    logic [WORD_WIDTH-1:0] t;

    always_comb begin
        f = (rotl(x_i, 1) & rotl(x_i, 8)) ^ rotl(x_i, 2);
        t = rotr(k3_i, 3) ^ k1_i;
    end

    assign x_o  = y_i ^ f ^ k0_i;
    assign y_o  = x_i;
    assign k0_o = k1_i;
    assign k1_o = k2_i;
    assign k2_o = k3_i;
    assign k3_o = C ^ {{(WORD_WIDTH-1){1'b0}}, z_i} ^ k0_i ^ t ^ rotr(t, 1);

endmodule

// File: rtl/simon_core.sv
// Iterative Simon128/256 encryptor; one round per cycle, or two with SIMON_CORE_UNROLL2_EN.
// Latency: done rises 72 (36 unrolled) edges after the capture edge.
// No backpressure: a start rising edge while busy is ignored, nothing is queued.
module simon_core
    import simon_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int ROUNDS    = ROUNDS_128_256
) (
    input  logic                 aclk,
    input  logic                 arst_n,
    input  logic [REG_WIDTH-1:0] inp_data_0,
    input  logic [REG_WIDTH-1:0] inp_data_1,
    input  logic [REG_WIDTH-1:0] inp_data_2,
    input  logic [REG_WIDTH-1:0] inp_data_3,
    input  logic [REG_WIDTH-1:0] inp_key_0,
    input  logic [REG_WIDTH-1:0] inp_key_1,
    input  logic [REG_WIDTH-1:0] inp_key_2,
    input  logic [REG_WIDTH-1:0] inp_key_3,
    input  logic [REG_WIDTH-1:0] inp_key_4,
    input  logic [REG_WIDTH-1:0] inp_key_5,
    input  logic [REG_WIDTH-1:0] inp_key_6,
    input  logic [REG_WIDTH-1:0] inp_key_7,
    input  logic                 start,
    output logic                 done,
    output logic                 busy,
    output logic [REG_WIDTH-1:0] out_data_0,
    output logic [REG_WIDTH-1:0] out_data_1,
    output logic [REG_WIDTH-1:0] out_data_2,
    output logic [REG_WIDTH-1:0] out_data_3
);

`ifdef SIMON_CORE_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [6:0] LAST = 7'(ROUNDS - STEP);

    state_t                state_q, state_d;
    logic                  start_q;
    logic                  start_rise;
    logic [6:0]            cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WORD_WIDTH-1:0] k0_q, k0_d, k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [WORD_WIDTH-1:0] out_x_q, out_x_d, out_y_q, out_y_d;

    logic [WORD_WIDTH-1:0] r0_x, r0_y, r0_k0, r0_k1, r0_k2, r0_k3;
    logic [WORD_WIDTH-1:0] rn_x, rn_y, rn_k0, rn_k1, rn_k2, rn_k3;

    assign start_rise = start & ~start_q;

    simon_round u_round0 (
        .x_i  (x_q),   .y_i  (y_q),
        .k0_i (k0_q),  .k1_i (k1_q),  .k2_i (k2_q),  .k3_i (k3_q),
        .z_i  (z4_at(cnt_q)),
        .x_o  (r0_x),  .y_o  (r0_y),
        .k0_o (r0_k0), .k1_o (r0_k1), .k2_o (r0_k2), .k3_o (r0_k3)
    );

`ifdef SIMON_CORE_UNROLL2_EN
    simon_round u_round1 (
        .x_i  (r0_x),  .y_i  (r0_y),
        .k0_i (r0_k0), .k1_i (r0_k1), .k2_i (r0_k2), .k3_i (r0_k3),
        .z_i  (z4_at(cnt_q + 7'd1)),
        .x_o  (rn_x),  .y_o  (rn_y),
        .k0_o (rn_k0), .k1_o (rn_k1), .k2_o (rn_k2), .k3_o (rn_k3)
    );
`else
    assign rn_x  = r0_x;
    assign rn_y  = r0_y;
    assign rn_k0 = r0_k0;
    assign rn_k1 = r0_k1;
    assign rn_k2 = r0_k2;
    assign rn_k3 = r0_k3;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        k3_d    = k3_q;
        out_x_d = out_x_q;
        out_y_d = out_y_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    x_d     = {inp_data_3, inp_data_2};
                    y_d     = {inp_data_1, inp_data_0};
                    k0_d    = {inp_key_1, inp_key_0};
                    k1_d    = {inp_key_3, inp_key_2};
                    k2_d    = {inp_key_5, inp_key_4};
                    k3_d    = {inp_key_7, inp_key_6};
                    cnt_d   = 7'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = rn_x;
                y_d   = rn_y;
                k0_d  = rn_k0;
                k1_d  = rn_k1;
                k2_d  = rn_k2;
                k3_d  = rn_k3;
                cnt_d = cnt_q + 7'(STEP);
                if (cnt_q == LAST) begin
                    out_x_d = rn_x;
                    out_y_d = rn_y;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            out_x_q <= '0;
            out_y_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            k3_q    <= k3_d;
            out_x_q <= out_x_d;
            out_y_q <= out_y_d;
        end
    end

    assign done       = (state_q == DONE);
    assign busy       = (state_q == RUN);
    assign out_data_3 = out_x_q[63:32];
    assign out_data_2 = out_x_q[31:0];
    assign out_data_1 = out_y_q[63:32];
    assign out_data_0 = out_y_q[31:0];

endmodule

// File: tb/tb_simon_core.sv
// Directed bench for simon_core: known-answer vectors plus start/reset corner sequences.
module tb_simon_core;

`ifdef SIMON_CORE_UNROLL2_EN
    localparam int LAT    = 36;
    localparam int RST_AT = 20;
`else
    localparam int LAT    = 72;
    localparam int RST_AT = 40;
`endif
    localparam logic [61:0] ZSEQ = 62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef struct {
        logic [63:0]  x;
        logic [63:0]  y;
        logic [63:0]  k0;
        logic [63:0]  k1;
        logic [63:0]  k2;
        logic [63:0]  k3;
        logic [127:0] exp;
    } vec_t;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [31:0] kk0 = '0, kk1 = '0, kk2 = '0, kk3 = '0, kk4 = '0, kk5 = '0, kk6 = '0, kk7 = '0;
    logic        done, busy;
    logic [31:0] o0, o1, o2, o3;
    logic [127:0] out_all;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;
    assign out_all = {o3, o2, o1, o0};

    simon_core dut (
        .aclk(aclk), .arst_n(arst_n),
        .inp_data_0(d0), .inp_data_1(d1), .inp_data_2(d2), .inp_data_3(d3),
        .inp_key_0(kk0), .inp_key_1(kk1), .inp_key_2(kk2), .inp_key_3(kk3),
        .inp_key_4(kk4), .inp_key_5(kk5), .inp_key_6(kk6), .inp_key_7(kk7),
        .start(start), .done(done), .busy(busy),
        .out_data_0(o0), .out_data_1(o1), .out_data_2(o2), .out_data_3(o3)
    );

    function automatic logic [63:0] rl(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] rr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // Reference Simon128/256: full key expansion first, then 72 rounds.
    function automatic logic [127:0] model(input logic [63:0] x_in, input logic [63:0] y_in,
                                           input logic [63:0] a0, input logic [63:0] a1,
                                           input logic [63:0] a2, input logic [63:0] a3);
        logic [63:0] ks [0:71];
        logic [63:0] tmp, x, y;
        ks[0] = a0; ks[1] = a1; ks[2] = a2; ks[3] = a3;
        for (int i = 4; i < 72; i++) begin
            tmp = rr(ks[i-1], 3) ^ ks[i-3];
            tmp = tmp ^ rr(tmp, 1);
            ks[i] = ~ks[i-4] ^ tmp ^ {63'd0, ZSEQ[61 - ((i - 4) % 62)]} ^ 64'd3;
        end
        x = x_in; y = y_in;
        for (int i = 0; i < 72; i++) begin
            tmp = x;
            x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ ks[i];
            y = tmp;
        end
        return {x, y};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        {d3, d2} = v.x;
        {d1, d0} = v.y;
        {kk1, kk0} = v.k0;
        {kk3, kk2} = v.k1;
        {kk5, kk4} = v.k2;
        {kk7, kk6} = v.k3;
    endtask

    // Launch one operation and check capture, latency, held output and result.
    task automatic run_vec(input string name, input vec_t v, input logic [127:0] prev);
        int   e;
        logic held_bad;
        @(posedge aclk); #1;
        drive(v);
        start = 1'b1;
        @(posedge aclk); #1;
        chk({name, " busy@capture"}, {127'd0, busy}, 128'd1);
        chk({name, " done@capture"}, {127'd0, done}, 128'd0);
        e = 0;
        held_bad = 1'b0;
        while (done !== 1'b1 && e < 300) begin
            if (out_all !== prev) held_bad = 1'b1;
            @(posedge aclk); #1;
            e++;
        end
        chk({name, " latency"}, 128'(e), 128'(LAT));
        chk({name, " out_held"}, {127'd0, held_bad}, 128'd0);
        chk({name, " result"}, out_all, v.exp);
        chk({name, " busy@done"}, {127'd0, busy}, 128'd0);
        start = 1'b0;
    endtask

    vec_t vecs[4];
    vec_t kat;
    vec_t zero_v;

    initial begin
        int          e, rises;
        logic        prev_done, seen, busy_bad;
        logic [127:0] prev;

        kat.x  = 64'h74206e69206d6f6f;
        kat.y  = 64'h6d69732061207369;
        kat.k0 = 64'h0706050403020100;
        kat.k1 = 64'h0f0e0d0c0b0a0908;
        kat.k2 = 64'h1716151413121110;
        kat.k3 = 64'h1f1e1d1c1b1a1918;
        kat.exp = {32'h8d2b5579, 32'hafc8a3a0, 32'h3bf72a87, 32'hefe7b868};
        zero_v = '{x: '0, y: '0, k0: '0, k1: '0, k2: '0, k3: '0, exp: '0};

        vecs[0] = kat;
        vecs[1] = kat;
        vecs[1].x = '0;
        vecs[1].y = '0;
        vecs[2] = '{x: '1, y: '1, k0: '0, k1: '0, k2: '0, k3: '0, exp: '0};
        vecs[3] = '{x: 64'h0123456789abcdef, y: 64'hfedcba9876543210,
                    k0: 64'hdeadbeefcafef00d, k1: 64'h5555aaaa5555aaaa,
                    k2: 64'h0f0f0f0ff0f0f0f0, k3: 64'h8000000000000001, exp: '0};
        for (int i = 1; i < 4; i++) begin
            vecs[i].exp = model(vecs[i].x, vecs[i].y, vecs[i].k0, vecs[i].k1, vecs[i].k2, vecs[i].k3);
        end

        chk("model_kat", model(kat.x, kat.y, kat.k0, kat.k1, kat.k2, kat.k3), kat.exp);

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst done", {127'd0, done}, 128'd0);
        chk("rst busy", {127'd0, busy}, 128'd0);
        chk("rst out", out_all, 128'd0);
        arst_n = 1'b1;

        // Table: sequential runs, vecs[1] is the back-to-back zero-plaintext case
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i], prev);
            prev = vecs[i].exp;
        end

        // Start held high for 200 cycles launches exactly one operation
        @(posedge aclk); #1;
        drive(kat);
        start = 1'b1;
        prev_done = done;
        rises = 0;
        seen = 1'b0;
        busy_bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge aclk); #1;
            if (done && !prev_done) rises++;
            if (seen && busy) busy_bad = 1'b1;
            if (done) seen = 1'b1;
            prev_done = done;
        end
        chk("held rises", 128'(rises), 128'd1);
        chk("held busy", {127'd0, busy_bad}, 128'd0);
        chk("held done", {127'd0, done}, 128'd1);
        chk("held result", out_all, kat.exp);
        start = 1'b0;

        // Second rising start and zeroed inputs mid-run are ignored
        @(posedge aclk); #1;
        drive(kat);
        start = 1'b1;
        @(posedge aclk); #1;
        e = 0;
        while (done !== 1'b1 && e < 300) begin
            @(posedge aclk); #1;
            e++;
            if (e == 5) start = 1'b0;
            if (e == 10) begin
                start = 1'b1;
                drive(zero_v);
            end
        end
        chk("midstart latency", 128'(e), 128'(LAT));
        chk("midstart result", out_all, kat.exp);
        start = 1'b0;

        // Reset partway through a run aborts it
        @(posedge aclk); #1;
        drive(kat);
        start = 1'b1;
        @(posedge aclk); #1;
        repeat (RST_AT) @(posedge aclk);
        #1;
        chk("pre-rst busy", {127'd0, busy}, 128'd1);
        arst_n = 1'b0;
        start = 1'b0;
        @(posedge aclk); #1;
        chk("midrst done", {127'd0, done}, 128'd0);
        chk("midrst busy", {127'd0, busy}, 128'd0);
        chk("midrst out", out_all, 128'd0);
        arst_n = 1'b1;
        run_vec("after_rst", kat, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
